ram32_arbiter: RTL and testbench

Sequencer and arbiter for the single-port RAM32 macro shared between the SERV instruction bus, the SERV data bus and the external byte-wide host loader on the pin interface. It serialises all requests into single RAM32 accesses, forms byte-lane write enables, and returns Wishbone-style single-cycle acks. It sits between `serv_top`, the pin decode logic and the RAM32 instance, replacing the direct ack/data tie-offs.

---
 rtl/ram32_arbiter_if.sv | 57 +++++
 rtl/ram32_arbiter.sv | 167 ++++++++++++++++
 tb/tb_ram32_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram32_arbiter_if.sv
// Bus bundle between the RAM32 arbiter, its three requesters (SERV ibus, SERV dbus, host loader)
// and the RAM32 macro. The arbiter uses the slave modport; the requester/RAM side uses master.
interface ram32_arbiter_if;
  // Host byte loader
  logic        host_req;
  logic        host_we;
  logic [6:0]  host_addr;
  logic [7:0]  host_wdata;
  logic [7:0]  host_rdata;
  logic        host_ack;
  // SERV instruction bus
  logic        ibus_cyc;
  logic [31:0] ibus_adr;
  logic [31:0] ibus_rdt;
  logic        ibus_ack;
  // SERV data bus
  logic        dbus_cyc;
  logic [31:0] dbus_adr;
  logic        dbus_we;
  logic [31:0] dbus_dat;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_rdt;
  logic        dbus_ack;
  // RAM32 macro port
  logic        ram_en;
  logic [4:0]  ram_a;
  logic [3:0]  ram_we;
  logic [31:0] ram_di;
  logic [31:0] ram_do;
  // Status
  logic [1:0]  grant;
  logic        busy;

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_rdata, host_ack,
    input  ibus_cyc, ibus_adr,
    output ibus_rdt, ibus_ack,
    input  dbus_cyc, dbus_adr, dbus_we, dbus_dat, dbus_sel,
    output dbus_rdt, dbus_ack,
    output ram_en, ram_a, ram_we, ram_di,
    input  ram_do,
    output grant, busy
  );

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_rdata, host_ack,
    output ibus_cyc, ibus_adr,
    input  ibus_rdt, ibus_ack,
    output dbus_cyc, dbus_adr, dbus_we, dbus_dat, dbus_sel,
    input  dbus_rdt, dbus_ack,
    input  ram_en, ram_a, ram_we, ram_di,
    output ram_do,
    input  grant, busy
  );
endinterface

// File: rtl/ram32_arbiter.sv
// Serialises host, SERV dbus and SERV ibus requests onto one RAM32 port (IDLE/ISSUE/RESP).
// Optional macro ARB_ROUND_ROBIN_EN: round-robin between ibus and dbus instead of dbus > ibus.
module ram32_arbiter (
  input  logic                  clk,
  input  logic                  rst_n,
  ram32_arbiter_if.slave        bus,
  output logic [1:0]            dbg_state_o
);

  // Handshake: a requester raises req/cyc with its address/data and holds them unchanged
  // until its one-cycle ack; it drops the request in the cycle after the ack. Requests
  // are only sampled in IDLE, so anything raised during ISSUE/RESP waits for the next IDLE.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam logic [1:0] GR_NONE = 2'b00;
  localparam logic [1:0] GR_IBUS = 2'b01;
  localparam logic [1:0] GR_DBUS = 2'b10;
  localparam logic [1:0] GR_HOST = 2'b11;

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [7:0]  host_rdata_q, host_rdata_d;
  logic [1:0]  winner;
  logic        dbus_first;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = ibus was the last of the two SERV buses served, so dbus goes first on a tie.
  logic last_ibus_q, last_ibus_d;

  always_comb begin
    last_ibus_d = last_ibus_q;
    if (state_q == ST_IDLE) begin
      if (winner == GR_IBUS) begin
        last_ibus_d = 1'b1;
      end else if (winner == GR_DBUS) begin
        last_ibus_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_ibus_q <= 1'b1;
    end else begin
      last_ibus_q <= last_ibus_d;
    end
  end

  assign dbus_first = last_ibus_q;
`else
  assign dbus_first = 1'b1;
`endif

  // Host always wins; dbus_first settles an ibus/dbus tie.
  always_comb begin
    winner = GR_NONE;
    if (bus.host_req) begin
      winner = GR_HOST;
    end else if (bus.dbus_cyc && (dbus_first || !bus.ibus_cyc)) begin
      winner = GR_DBUS;
    end else if (bus.ibus_cyc) begin
      winner = GR_IBUS;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (winner != GR_NONE) begin
          state_d = ST_ISSUE;
          grant_d = winner;
        end
      end
      ST_ISSUE: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        grant_d = GR_NONE;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = GR_NONE;
      end
    endcase
  end

  // Host read data is captured from the addressed lane at the end of RESP.
  always_comb begin
    host_rdata_d = host_rdata_q;
    if (state_q == ST_RESP && grant_q == GR_HOST && !bus.host_we) begin
      host_rdata_d = bus.ram_do[{bus.host_addr[1:0], 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= GR_NONE;
      host_rdata_q <= 8'h00;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  // RAM strobes and acks are gated by rst_n so a reset during ISSUE kills the write at once.
  always_comb begin
    bus.ram_en   = 1'b0;
    bus.ram_a    = 5'd0;
    bus.ram_we   = 4'b0000;
    bus.ram_di   = 32'd0;
    bus.ibus_rdt = 32'd0;
    bus.dbus_rdt = 32'd0;
    bus.ibus_ack = 1'b0;
    bus.dbus_ack = 1'b0;
    bus.host_ack = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_ISSUE: begin
          bus.ram_en = 1'b1;
          case (grant_q)
            GR_IBUS: begin
              bus.ram_a = bus.ibus_adr[6:2];
            end
            GR_DBUS: begin
              bus.ram_a  = bus.dbus_adr[6:2];
              bus.ram_we = bus.dbus_we ? bus.dbus_sel : 4'b0000;
              bus.ram_di = bus.dbus_dat;
            end
            GR_HOST: begin
              bus.ram_a  = bus.host_addr[6:2];
              bus.ram_we = bus.host_we ? (4'b0001 << bus.host_addr[1:0]) : 4'b0000;
              bus.ram_di = {4{bus.host_wdata}};
            end
            default: begin
              bus.ram_en = 1'b0;
            end
          endcase
        end
        ST_RESP: begin
          bus.ibus_rdt = bus.ram_do;
          bus.dbus_rdt = bus.ram_do;
          bus.ibus_ack = (grant_q == GR_IBUS);
          bus.dbus_ack = (grant_q == GR_DBUS);
          bus.host_ack = (grant_q == GR_HOST);
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.grant      = grant_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.host_rdata = host_rdata_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_ram32_arbiter.sv
// Directed bench for ram32_arbiter: drivers push expected RAM strobes and acks into queues,
// a negedge monitor pops and compares them; a behavioural RAM32 model answers ram_do.
module tb_ram32_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  dbg_state;
  int          cyc;
  int          n_cmp;
  int          n_fail;
  logic        mem_clr;
  logic [31:0] mem [32];

  logic [41:0] exp_ram_q [$];  // {chk_di, a, we, di}
  logic [37:0] exp_ack_q [$];  // {chk_rdt, grant, host/dbus/ibus ack, rdt}
  logic [7:0]  exp_hr_q  [$];

  ram32_arbiter_if bus ();

  ram32_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset / RAM model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
      bus.ram_do <= 32'd0;
    end else if (bus.ram_en) begin
      bus.ram_do <= mem[bus.ram_a];
      for (int l = 0; l < 4; l++)
        if (bus.ram_we[l]) mem[bus.ram_a][8*l +: 8] <= bus.ram_di[8*l +: 8];
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic exp_ram(input logic chk_di, input logic [4:0] a, input logic [3:0] we,
                         input logic [31:0] di);
    exp_ram_q.push_back({chk_di, a, we, di});
  endtask

  task automatic exp_ack(input logic chk_rdt, input logic [1:0] gr, input logic [2:0] acks,
                         input logic [31:0] rdt);
    exp_ack_q.push_back({chk_rdt, gr, acks, rdt});
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_lat(input string name, input int start, input int lat, input int who);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if ((who == 0 && bus.host_ack) || (who == 1 && bus.dbus_ack) ||
          (who == 2 && bus.ibus_ack)) begin
        seen = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_timeout: no ack within 30 cycles, expected latency %0d", name, lat);
    end else if (cyc - start != lat) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d expected %0d", name, cyc - start, lat);
    end
  endtask

  task automatic host_drive(input logic we, input logic [6:0] addr, input logic [7:0] wd,
                            input int lat);
    int start;
    @(posedge clk); #1;
    bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = addr; bus.host_wdata = wd;
    start = cyc;
    wait_lat("host", start, lat, 0);
    @(posedge clk); #1;
    bus.host_req = 1'b0;
  endtask

  task automatic dbus_drive(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input int lat);
    int start;
    @(posedge clk); #1;
    bus.dbus_cyc = 1'b1; bus.dbus_we = we; bus.dbus_adr = adr;
    bus.dbus_dat = dat; bus.dbus_sel = sel;
    start = cyc;
    wait_lat("dbus", start, lat, 1);
    @(posedge clk); #1;
    bus.dbus_cyc = 1'b0;
  endtask

  task automatic ibus_drive(input logic [31:0] adr, input int lat);
    int start;
    @(posedge clk); #1;
    bus.ibus_cyc = 1'b1; bus.ibus_adr = adr;
    start = cyc;
    wait_lat("ibus", start, lat, 2);
    @(posedge clk); #1;
    bus.ibus_cyc = 1'b0;
  endtask

  task automatic check_reset_values();
    chk("rst_grant",      {30'd0, bus.grant}, 32'd0);
    chk("rst_busy",       {31'd0, bus.busy}, 32'd0);
    chk("rst_state",      {30'd0, dbg_state}, 32'd0);
    chk("rst_acks",       {29'd0, bus.host_ack, bus.dbus_ack, bus.ibus_ack}, 32'd0);
    chk("rst_ram_ctl",    {22'd0, bus.ram_en, bus.ram_a, bus.ram_we}, 32'd0);
    chk("rst_ram_di",     bus.ram_di, 32'd0);
    chk("rst_host_rdata", {24'd0, bus.host_rdata}, 32'd0);
    chk("rst_ibus_rdt",   bus.ibus_rdt, 32'd0);
    chk("rst_dbus_rdt",   bus.dbus_rdt, 32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [41:0] er;
    logic [37:0] ea;
    logic [7:0]  eh;
    logic [31:0] rdt;
    bit          hr_pend;
    hr_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (hr_pend) begin
        hr_pend = 1'b0;
        n_cmp++;
        if (exp_hr_q.size() == 0) begin
          n_fail++;
          $display("FAIL host_rdata_unexpected: got %h", bus.host_rdata);
        end else begin
          eh = exp_hr_q.pop_front();
          if (bus.host_rdata !== eh) begin
            n_fail++;
            $display("FAIL host_rdata: got %h expected %h", bus.host_rdata, eh);
          end
        end
      end
      if (bus.ram_en) begin
        n_cmp++;
        if (exp_ram_q.size() == 0) begin
          n_fail++;
          $display("FAIL ram_unexpected: a=%h we=%h di=%h", bus.ram_a, bus.ram_we, bus.ram_di);
        end else begin
          er = exp_ram_q.pop_front();
          if (bus.ram_a !== er[40:36] || bus.ram_we !== er[35:32] ||
              (er[41] && bus.ram_di !== er[31:0])) begin
            n_fail++;
            $display("FAIL ram_issue: got a=%h we=%h di=%h expected a=%h we=%h di=%h",
                     bus.ram_a, bus.ram_we, bus.ram_di, er[40:36], er[35:32], er[31:0]);
          end
        end
      end
      if (bus.host_ack || bus.dbus_ack || bus.ibus_ack) begin
        rdt = (bus.grant == 2'b01) ? bus.ibus_rdt : bus.dbus_rdt;
        n_cmp++;
        if (exp_ack_q.size() == 0) begin
          n_fail++;
          $display("FAIL ack_unexpected: grant=%b acks=%b%b%b", bus.grant,
                   bus.host_ack, bus.dbus_ack, bus.ibus_ack);
        end else begin
          ea = exp_ack_q.pop_front();
          if (bus.grant !== ea[36:35] ||
              {bus.host_ack, bus.dbus_ack, bus.ibus_ack} !== ea[34:32] ||
              (ea[37] && rdt !== ea[31:0])) begin
            n_fail++;
            $display("FAIL ack: got grant=%b acks=%b%b%b rdt=%h expected grant=%b acks=%b rdt=%h",
                     bus.grant, bus.host_ack, bus.dbus_ack, bus.ibus_ack, rdt,
                     ea[36:35], ea[34:32], ea[31:0]);
          end
        end
        if (bus.host_ack && !bus.host_we) hr_pend = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int nack;
    cyc = 0; n_cmp = 0; n_fail = 0;
    rst_n = 1'b0; mem_clr = 1'b1;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = 7'd0; bus.host_wdata = 8'd0;
    bus.ibus_cyc = 1'b0; bus.ibus_adr = 32'd0;
    bus.dbus_cyc = 1'b0; bus.dbus_adr = 32'd0; bus.dbus_we = 1'b0;
    bus.dbus_dat = 32'd0; bus.dbus_sel = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    mem_clr = 1'b0;
    rst_n = 1'b1;

    // Host byte write to lane 1 of word 1, then read it back.
    exp_ram(1'b1, 5'd1, 4'b0010, 32'hA5A5_A5A5);
    exp_ack(1'b0, 2'b11, 3'b100, 32'd0);
    host_drive(1'b1, 7'h05, 8'hA5, 2);
    exp_ram(1'b0, 5'd1, 4'b0000, 32'd0);
    exp_ack(1'b0, 2'b11, 3'b100, 32'd0);
    exp_hr_q.push_back(8'hA5);
    host_drive(1'b0, 7'h05, 8'h00, 2);

    // dbus word write, ibus fetch of the same word.
    exp_ram(1'b1, 5'd4, 4'hF, 32'hDEAD_BEEF);
    exp_ack(1'b0, 2'b10, 3'b010, 32'd0);
    dbus_drive(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2);
    exp_ram(1'b0, 5'd4, 4'h0, 32'd0);
    exp_ack(1'b1, 2'b01, 3'b001, 32'hDEAD_BEEF);
    ibus_drive(32'h0000_0010, 2);

    // Aliased address with sel=0: acked, no write; word 1 keeps only the host byte.
    exp_ram(1'b1, 5'd1, 4'h0, 32'hFFFF_FFFF);
    exp_ack(1'b0, 2'b10, 3'b010, 32'd0);
    dbus_drive(1'b1, 32'h0000_0084, 32'hFFFF_FFFF, 4'h0, 2);
    exp_ram(1'b0, 5'd1, 4'h0, 32'd0);
    exp_ack(1'b1, 2'b10, 3'b010, 32'h0000_A500);
    dbus_drive(1'b0, 32'h0000_0004, 32'd0, 4'h0, 2);

    // Three-way collision: host, dbus, ibus with acks at cycles 2, 5, 8.
    exp_ram(1'b0, 5'd1, 4'h0, 32'd0);
    exp_ack(1'b0, 2'b11, 3'b100, 32'd0);
    exp_hr_q.push_back(8'hA5);
    exp_ram(1'b0, 5'd4, 4'h0, 32'd0);
    exp_ack(1'b1, 2'b10, 3'b010, 32'hDEAD_BEEF);
    exp_ram(1'b0, 5'd4, 4'h0, 32'd0);
    exp_ack(1'b1, 2'b01, 3'b001, 32'hDEAD_BEEF);
    fork
      host_drive(1'b0, 7'h05, 8'h00, 2);
      dbus_drive(1'b0, 32'h0000_0010, 32'd0, 4'h0, 5);
      ibus_drive(32'h0000_0090, 8);
    join

    // Seed word 0 for the reset test.
    exp_ram(1'b1, 5'd0, 4'hF, 32'h1122_3344);
    exp_ack(1'b0, 2'b10, 3'b010, 32'd0);
    dbus_drive(1'b1, 32'h0000_0000, 32'h1122_3344, 4'hF, 2);

    // Reset during ISSUE of a host write to word 0.
    @(posedge clk); #1;
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 7'h00; bus.host_wdata = 8'h5A;
    @(posedge clk); #1;
    chk("abort_in_issue", {30'd0, dbg_state}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_ram_en", {31'd0, bus.ram_en}, 32'd0);
    chk("abort_ram_we", {28'd0, bus.ram_we}, 32'd0);
    bus.host_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    rst_n = 1'b1;

    // Continuous ibus/dbus contention straight out of reset, 4 transactions.
    for (int t = 0; t < 4; t++) begin
      exp_ram(1'b0, 5'd4, 4'h0, 32'd0);
`ifdef ARB_ROUND_ROBIN_EN
      if (t % 2 == 0) exp_ack(1'b1, 2'b10, 3'b010, 32'hDEAD_BEEF);
      else            exp_ack(1'b1, 2'b01, 3'b001, 32'hDEAD_BEEF);
`else
      exp_ack(1'b1, 2'b10, 3'b010, 32'hDEAD_BEEF);
`endif
    end
    @(posedge clk); #1;
    bus.dbus_cyc = 1'b1; bus.dbus_we = 1'b0; bus.dbus_adr = 32'h0000_0010;
    bus.ibus_cyc = 1'b1; bus.ibus_adr = 32'h0000_0010;
    nack = 0;
    for (int k = 0; k < 40 && nack < 4; k++) begin
      @(negedge clk);
      if (bus.dbus_ack || bus.ibus_ack) nack++;
    end
    chk("contention_acks", nack, 32'd4);
    @(posedge clk); #1;
    bus.dbus_cyc = 1'b0; bus.ibus_cyc = 1'b0;

    // Word 0 survived the aborted write.
    exp_ram(1'b0, 5'd0, 4'h0, 32'd0);
    exp_ack(1'b1, 2'b10, 3'b010, 32'h1122_3344);
    dbus_drive(1'b0, 32'h0000_0000, 32'd0, 4'h0, 2);

    repeat (4) @(posedge clk);
    #1;
    chk("left_ram_exp", exp_ram_q.size(), 32'd0);
    chk("left_ack_exp", exp_ack_q.size(), 32'd0);
    chk("left_hr_exp",  exp_hr_q.size(),  32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
